serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//   Parametrised serial frame transmitter: one start bit, DATA_W data bits LSB-first,
//   optional parity bit, then 1 or 2 stop bits. Each bit lasts DIVISOR clk_in cycles.
//   Words are accepted over a valid/ready handshake and latched internally, so the
//   source may change val_in after acceptance. Frames can run back-to-back on the line.
// PARAMETERS
//   DATA_W     162   payload bits per frame (>=1)
//   DIVISOR    6771  clk_in cycles per line bit (>=2)
//   PARITY     0     0 = none, 1 = even, 2 = odd (computed over latched payload)
//   STOP_BITS  1     number of stop bits, 1 or 2
// PORTS
//   clk_in     in   1       system clock
//   rst_n_in   in   1       asynchronous active-low reset
//   valid_in   in   1       val_in holds a word to send
//   val_in     in   DATA_W  payload; sampled only on accept
//   ready_out  out  1       block can accept a word this cycle
//   busy_out   out  1       frame in progress (start through last stop bit)
//   done_out   out  1       1-cycle pulse in the last cycle of the final stop bit
//   data_out   out  1       serial line; idles high
// BEHAVIOUR
// - Reset (async assert, sync release): data_out=1, ready_out=1, busy_out=0, done_out=0,
//   FSM=IDLE, all counters cleared. Reset mid-frame aborts the frame; line returns high at once.
// - Accept: valid_in & ready_out at a rising edge. Payload and parity latched on that edge.
// - FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE or START.
//   Every state holds its bit for exactly DIVISOR cycles, timed by a down-counter
//   of width $clog2(DIVISOR) loaded with DIVISOR-1 on state entry; bit ends at count 0.
//   Bit index counter width $clog2(DATA_W+1); DATA sends bit 0 first, leaves after bit DATA_W-1.
//   STOP counts STOP_BITS periods of data_out=1.
// - Latency: data_out goes low (start bit) the cycle after accept (registered output).
// - Frame length: (1 + DATA_W + (PARITY!=0) + STOP_BITS) * DIVISOR cycles, no gaps.
// - ready_out: high in IDLE, and also during the final cycle of the last stop bit
//   (same cycle as done_out). Low otherwise. valid_in while ready_out=0 is ignored,
//   nothing is queued.
// - Back-to-back: accept in the last stop-bit cycle -> next cycle is START; no idle bit.
//   No accept there -> IDLE, data_out stays 1.
// - busy_out = (FSM != IDLE); done_out is high for exactly one cycle per frame.
// - Parity: even -> parity bit = ^payload; odd -> ~^payload.
// - Counters never wrap in use. The bit-index counter is compared against DATA_W-1, so
//   DATA_W that is not a power of two is handled without aliasing.
// TESTING
// 1 DATA_W=8,DIVISOR=4,PARITY=0: send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each 4 cyc;
//   done_out at cycle 40 after accept; ready_out=1 same cycle.
// 2 PARITY=1, 0x07 -> parity bit 1; PARITY=2, 0x07 -> 0; frame 44 cycles with 1 stop.
// 3 valid_in held high with 3 words, STOP_BITS=2 -> three 44-cyc frames, no idle gap,
//   3 done pulses; val_in changed 1 cycle after accept does not corrupt the frame.
// 4 valid_in pulsed mid-frame (ready_out=0) -> ignored; no extra frame; line idle after.
// 5 rst_n_in low during data bit 3 -> data_out=1 asynchronously, busy=0; after release
//   the next accept sends a full, correct frame.
// 6 DATA_W=162,DIVISOR=6771: random payload -> sampled mid-bit line decodes to payload;
//   frame = 164*6771 cycles.

Source files
------------

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_frame_tx
// Description : Serial frame transmitter. Start bit, LSB-first payload,
//               optional parity, 1 or 2 stop bits, DIVISOR clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
    parameter int DATA_W    = 162,
    parameter int DIVISOR   = 6771,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] val_in,
    output logic              ready_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              data_out
);

    localparam int CNT_W = $clog2(DIVISOR);
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam logic [CNT_W-1:0] c_CNT_RELOAD = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST   = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] c_STOP_LAST  = IDX_W'(STOP_BITS - 1);
    localparam bit               c_HAS_PAR    = (PARITY != 0);

    logic [2:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic              r_par, w_par_nxt;
    logic              r_line, w_line_nxt;
    logic              w_par_calc;
    logic              w_bit_end;
    logic              w_last_stop;
    logic              w_accept;

    generate
        if (PARITY == 2) begin : g_par_odd
            assign w_par_calc = ~^val_in;
        end else begin : g_par_even
            assign w_par_calc = ^val_in;
        end
    endgenerate

    assign w_bit_end   = (r_cnt == '0);
    assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_idx == c_STOP_LAST);

    // State and datapath registers; the line itself is registered so the start
    // bit appears the cycle after accept and reset forces it high immediately.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_line  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_line  <= w_line_nxt;
        end
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_accept    = valid_in && ready_out;

        if ((r_state != S_IDLE) && !w_bit_end) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = c_CNT_RELOAD;
                    w_idx_nxt   = '0;
                    w_shift_nxt = val_in;
                    w_par_nxt   = w_par_calc;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = c_CNT_RELOAD;
                    w_idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = c_CNT_RELOAD;
                    w_shift_nxt = r_shift >> 1;
                    if (r_idx == c_IDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = c_HAS_PAR ? S_PAR : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            S_PAR: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = c_CNT_RELOAD;
                    w_idx_nxt   = '0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_idx == c_STOP_LAST) begin
                        // Accept here chains the next frame with no idle bit.
                        if (w_accept) begin
                            w_state_nxt = S_START;
                            w_cnt_nxt   = c_CNT_RELOAD;
                            w_idx_nxt   = '0;
                            w_shift_nxt = val_in;
                            w_par_nxt   = w_par_calc;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_idx_nxt   = '0;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_cnt_nxt = c_CNT_RELOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase

        case (w_state_nxt)
            S_START: w_line_nxt = 1'b0;
            S_DATA:  w_line_nxt = w_shift_nxt[0];
            S_PAR:   w_line_nxt = w_par_nxt;
            default: w_line_nxt = 1'b1;
        endcase
    end

    always_comb begin : outputs
        ready_out = (r_state == S_IDLE) || w_last_stop;
        done_out  = w_last_stop;
        busy_out  = (r_state != S_IDLE);
        data_out  = r_line;
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_frame_tx
// Description : Scoreboard bench for serial_frame_tx over five configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

    typedef struct {
        int           inst;
        logic [169:0] bits;
    } frame_t;

    localparam int c_TMO = 5000;

    logic               clk;
    logic               rst_n;
    logic [4:0]         valid_bus;
    logic [161:0]       val_bus [5];
    logic [4:0]         ready_w, busy_w, done_w, line_w;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    int     done_cnt = 0;
    int     last_done_cyc = 0;
    frame_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < 5; g++) begin : g_dut
            localparam int W  = (g == 4) ? 162 : 8;
            localparam int D  = (g == 4) ? 5 : 4;
            localparam int P  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
            localparam int S  = (g == 3) ? 2 : 1;
            localparam int NB = 1 + W + ((P != 0) ? 1 : 0) + S;

            serial_frame_tx #(
                .DATA_W    (W),
                .DIVISOR   (D),
                .PARITY    (P),
                .STOP_BITS (S)
            ) u_dut (
                .clk_in    (clk),
                .rst_n_in  (rst_n),
                .valid_in  (valid_bus[g]),
                .val_in    (val_bus[g][W-1:0]),
                .ready_out (ready_w[g]),
                .busy_out  (busy_w[g]),
                .done_out  (done_w[g]),
                .data_out  (line_w[g])
            );

            logic   hist[$];
            frame_t e;
            int     bad;

            always @(negedge clk) begin
                if (!rst_n) begin
                    hist.delete();
                end else begin
                    if (busy_w[g]) begin
                        hist.push_back(line_w[g]);
                    end else begin
                        checks++;
                        if (line_w[g] !== 1'b1) begin
                            errors++;
                            $display("FAIL idle_line inst %0d cyc %0d got %b exp 1", g, cyc, line_w[g]);
                        end
                    end
                    if (done_w[g]) begin
                        done_cnt++;
                        last_done_cyc = cyc;
                        checks++;
                        if (ready_w[g] !== 1'b1) begin
                            errors++;
                            $display("FAIL ready_at_done inst %0d got %b exp 1", g, ready_w[g]);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_frame inst %0d got frame exp none", g);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.inst != g || hist.size() != NB * D) begin
                                errors++;
                                $display("FAIL frame_shape inst %0d got len %0d exp inst %0d len %0d",
                                         g, hist.size(), e.inst, NB * D);
                            end else begin
                                bad = -1;
                                for (int i = 0; i < NB * D; i++) begin
                                    if (hist[i] !== e.bits[i / D]) begin
                                        bad = i;
                                        break;
                                    end
                                end
                                if (bad >= 0) begin
                                    errors++;
                                    $display("FAIL frame_bits inst %0d sample %0d got %b exp %b",
                                             g, bad, hist[bad], e.bits[bad / D]);
                                end
                            end
                        end
                        hist.delete();
                    end
                end
            end
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns the cycle index of the accepting edge.
    task automatic send(input int g, input logic [161:0] v, input logic [169:0] exp,
                        input bit hold, output int acc_cyc);
        int     n;
        frame_t f;
        n = 0;
        valid_bus[g] = 1'b1;
        val_bus[g]   = v;
        while (ready_w[g] !== 1'b1 && n < c_TMO) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= c_TMO) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst %0d got busy exp ready", g);
            valid_bus[g] = 1'b0;
            acc_cyc = cyc;
            return;
        end
        f.inst = g;
        f.bits = exp;
        exp_q.push_back(f);
        @(posedge clk); #1;
        acc_cyc    = cyc;
        val_bus[g] = ~v;
        if (!hold) valid_bus[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (busy_w[g] && n < c_TMO) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= c_TMO) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout inst %0d got busy exp idle", g);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a0, dc;
        logic [161:0] big;

        rst_n     = 1'b0;
        valid_bus = '0;
        for (int i = 0; i < 5; i++) val_bus[i] = '0;
        #23;
        check("rst_line",  32'(line_w),  32'h1f);
        check("rst_ready", 32'(ready_w), 32'h1f);
        check("rst_busy",  32'(busy_w),  32'h0);
        check("rst_done",  32'(done_w),  32'h0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // 0xA5, no parity: done in the 40th cycle after accept
        dc = done_cnt;
        send(0, 162'hA5, 170'b1101001010, 1'b0, a);
        wait_idle(0);
        check("a5_done_count", 32'(done_cnt), 32'(dc + 1));
        check("a5_done_cycle", 32'(last_done_cyc - a), 32'd39);

        // Parity variants
        send(1, 162'h07, 170'b11000001110, 1'b0, a);
        wait_idle(1);
        send(2, 162'h07, 170'b10000001110, 1'b0, a);
        wait_idle(2);
        send(1, 162'hFF, 170'b10111111110, 1'b0, a);
        wait_idle(1);
        send(2, 162'h00, 170'b11000000000, 1'b0, a);
        wait_idle(2);

        // Back-to-back with 2 stop bits, valid held high
        dc = done_cnt;
        send(3, 162'h5A, 170'b11010110100, 1'b1, a0);
        send(3, 162'hFF, 170'b11111111110, 1'b1, a);
        check("b2b_gap1", 32'(a - a0), 32'd44);
        send(3, 162'h00, 170'b11000000000, 1'b0, a);
        wait_idle(3);
        check("b2b_done_count", 32'(done_cnt), 32'(dc + 3));
        check("b2b_span", 32'(last_done_cyc - a0), 32'd131);

        // Valid pulsed mid-frame is ignored
        dc = done_cnt;
        send(0, 162'h81, 170'b1100000010, 1'b0, a);
        repeat (10) @(posedge clk);
        #1;
        check("mid_ready", 32'(ready_w[0]), 32'h0);
        valid_bus[0] = 1'b1;
        val_bus[0]   = 162'hFF;
        @(posedge clk); #1;
        valid_bus[0] = 1'b0;
        wait_idle(0);
        repeat (30) @(posedge clk);
        #1;
        check("ignored_done_count", 32'(done_cnt), 32'(dc + 1));
        check("ignored_busy", 32'(busy_w[0]), 32'h0);

        // Reset during data bit 3 (payload bit 3 is 0)
        dc = done_cnt;
        send(0, 162'hC3, 170'b1110000110, 1'b0, a);
        repeat (17) @(posedge clk);
        #1;
        check("pre_rst_line", 32'(line_w[0]), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_line",  32'(line_w[0]),  32'h1);
        check("async_rst_busy",  32'(busy_w[0]),  32'h0);
        check("async_rst_ready", 32'(ready_w[0]), 32'h1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 162'hC3, 170'b1110000110, 1'b0, a);
        wait_idle(0);
        check("post_rst_done_count", 32'(done_cnt), 32'(dc + 1));

        // Wide payload, non-power-of-two width
        big = 162'h3_0123456789ABCDEF_FEDCBA9876543210_A5A5C3C3;
        send(4, big, {6'b0, 1'b1, big, 1'b0}, 1'b0, a);
        wait_idle(4);
        check("wide_done_cycle", 32'(last_done_cyc - a), 32'd819);
        big = {1'b1, 160'b0, 1'b1};
        send(4, big, {6'b0, 1'b1, big, 1'b0}, 1'b0, a);
        wait_idle(4);

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
